// File: rtl/datapath_responder.sv
// Datapath-to-memory responder: arbitrates fetch and data requests onto one
// variable-latency RAM port, with per-stream counters and a timeout watchdog.
module datapath_responder #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        halt,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready,
    output logic [31:0] icount,
    output logic [31:0] dcount,
    output logic        err
);

    localparam int unsigned WW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {IDLE, IACC, DACC, RESP, HALTED} state_t;

    state_t        state, state_n;
    logic [WW-1:0] wcnt, wcnt_n;
    logic          write_q, write_n;
    logic          ihit_n, dhit_n, ren_n, wen_n, err_n;
    logic [31:0]   imemload_n, dmemload_n, addr_n, store_n, icount_n, dcount_n;

    always_comb begin
        state_n    = state;
        wcnt_n     = wcnt;
        write_n    = write_q;
        ihit_n     = 1'b0;
        dhit_n     = 1'b0;
        err_n      = err;
        imemload_n = imemload;
        dmemload_n = dmemload;
        addr_n     = ram_addr;
        store_n    = ram_store;
        icount_n   = icount;
        dcount_n   = dcount;

        case (state)
            // Data wins over fetch; fetches are only launched from IDLE when not halted.
            IDLE, HALTED: begin
                if (dmemREN || dmemWEN) begin
                    state_n = DACC;
                    addr_n  = dmemaddr & WORD_MASK;
                    store_n = dmemstore;
                    write_n = dmemWEN;
                    wcnt_n  = '0;
                end else if (state == IDLE && imemREN && !halt) begin
                    state_n = IACC;
                    addr_n  = imemaddr & WORD_MASK;
                    write_n = 1'b0;
                    wcnt_n  = '0;
                end else if (halt) begin
                    state_n = HALTED;
                end else begin
                    state_n = IDLE;
                end
            end
            IACC, DACC: begin
                if (ram_ready || wcnt == WW'(TIMEOUT - 1)) begin
                    state_n = RESP;
                    wcnt_n  = '0;
                    if (!ram_ready) err_n = 1'b1;
                    if (state == IACC) begin
                        ihit_n     = 1'b1;
                        icount_n   = icount + 32'd1;
                        imemload_n = ram_ready ? ram_load : ERR_WORD;
                    end else begin
                        dhit_n   = 1'b1;
                        dcount_n = dcount + 32'd1;
                        if (!write_q) dmemload_n = ram_ready ? ram_load : ERR_WORD;
                    end
                end else begin
                    wcnt_n = wcnt + 1'b1;
                end
            end
            // One dead cycle so the still-held request is not relaunched.
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase

        ren_n = (state_n == IACC) || (state_n == DACC && !write_n);
        wen_n = (state_n == DACC) && write_n;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            wcnt      <= '0;
            write_q   <= 1'b0;
            ihit      <= 1'b0;
            dhit      <= 1'b0;
            imemload  <= '0;
            dmemload  <= '0;
            ram_ren   <= 1'b0;
            ram_wen   <= 1'b0;
            ram_addr  <= '0;
            ram_store <= '0;
            icount    <= '0;
            dcount    <= '0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            wcnt      <= wcnt_n;
            write_q   <= write_n;
            ihit      <= ihit_n;
            dhit      <= dhit_n;
            imemload  <= imemload_n;
            dmemload  <= dmemload_n;
            ram_ren   <= ren_n;
            ram_wen   <= wen_n;
            ram_addr  <= addr_n;
            ram_store <= store_n;
            icount    <= icount_n;
            dcount    <= dcount_n;
            err       <= err_n;
        end
    end

endmodule
